// File: rtl/usb_report_fifo.sv
// ULPI host report buffer: parametrised FIFO with duplicate
// suppression, full policy and ready/valid drain.
module usb_report_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int FILTER_DUP = 1,
  parameter int OVERWRITE  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [15:0]       drop_q;
  logic              ovf_q;
  logic              valid_q;
  logic [DATA_W-1:0] ref_q;
  logic              ref_ok;

  logic full;
  logic pop;
  logic is_dup;
  logic cand;
  logic wr_en;
  logic drop;
  logic adv_rd;

  assign full   = (cnt_q == CW'(DEPTH));
  assign pop    = valid_q & out_ready;
  assign is_dup = (FILTER_DUP != 0) & ref_ok
                & (in_data == ref_q);
  assign cand   = in_valid & ~is_dup;
  assign drop   = cand & full & ~pop;
  assign wr_en  = cand & (~full | pop
                | (OVERWRITE != 0));
  // Overwrite on full retires the head as the new word lands
  assign adv_rd = pop | (drop & (OVERWRITE != 0));

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en & ~adv_rd)
      cnt_d = cnt_q + CW'(1);
    else if (adv_rd & ~wr_en)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      ref_ok  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        ref_q  <= in_data;
        ref_ok <= 1'b1;
      end
      if (adv_rd)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      if (drop)
        ovf_q <= 1'b1;
      else if (clr_overflow)
        ovf_q <= 1'b0;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = valid_q;
  assign count     = cnt_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_usb_report_fifo.sv
// Bench for usb_report_fifo: three policy variants, scenario
// checks plus a queue-based reference model under random traffic.
module tb_usb_report_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr = 1'b0;

  logic [W-1:0] od  [3];
  logic         ov  [3];
  logic [3:0]   cnt [3];
  logic [15:0]  dc  [3];
  logic         of  [3];

  int nchk = 0;
  int nfail = 0;

  // 0: filter+drop, 1: no filter+drop, 2: filter+overwrite
  for (genvar g = 0; g < 3; g++) begin : g_dut
    usb_report_fifo #(
      .DATA_W(W), .DEPTH(D),
      .FILTER_DUP(g != 1 ? 1 : 0),
      .OVERWRITE(g == 2 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid),
      .out_data(od[g]), .out_valid(ov[g]),
      .out_ready(out_ready), .count(cnt[g]),
      .drop_cnt(dc[g]), .overflow(of[g]),
      .clr_overflow(clr)
    );
  end

  always #5 clk = ~clk;

  logic [W-1:0] mq [3][$];
  logic [W-1:0] rf [3];
  bit           rv [3];
  int           mdrop [3];
  bit           movf [3];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      rv[i] = 0;
      mdrop[i] = 0;
      movf[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit fd;
      bit ow;
      bit pop;
      bit cand;
      bit drp;
      fd = (i != 1);
      ow = (i == 2);
      drp = 0;
      pop = (mq[i].size() != 0) && out_ready;
      cand = in_valid &&
             !(fd && rv[i] && in_data == rf[i]);
      if (pop) void'(mq[i].pop_front());
      if (cand) begin
        if (mq[i].size() < D) begin
          mq[i].push_back(in_data);
          rf[i] = in_data;
          rv[i] = 1;
        end else begin
          drp = 1;
          if (ow) begin
            void'(mq[i].pop_front());
            mq[i].push_back(in_data);
            rf[i] = in_data;
            rv[i] = 1;
          end
        end
      end
      if (drp) begin
        if (mdrop[i] < 16'hFFFF) mdrop[i]++;
        movf[i] = 1;
      end else if (clr) begin
        movf[i] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_data = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (ov[i] !== 1'b0 || cnt[i] !== 4'd0 ||
          dc[i] !== 16'd0 || of[i] !== 1'b0) begin
        nfail++;
        $display("FAIL reset inst%0d v=%b c=%0d d=%0d o=%b exp 0",
                 i, ov[i], cnt[i], dc[i], of[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] v [3];
    v = '{16'h11, 16'h22, 16'h33};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(v[k]);
      nchk++;
      if (ov[0] !== 1'b1 || od[0] !== v[k] ||
          cnt[0] !== 4'd1) begin
        nfail++;
        $display("FAIL basic k=%0d v=%b d=%h c=%0d exp d=%h c=1",
                 k, ov[0], od[0], cnt[0], v[k]);
      end
    end
    tick();
    nchk++;
    if (ov[0] !== 1'b0 || cnt[0] !== 4'd0 || dc[0] !== 16'd0) begin
      nfail++;
      $display("FAIL basic_end v=%b c=%0d d=%0d exp 0 0 0",
               ov[0], cnt[0], dc[0]);
    end
  endtask

  task automatic test_dup();
    logic [W-1:0] v [4];
    logic [W-1:0] ea [3];
    v = '{16'hAA, 16'hAA, 16'hBB, 16'hAA};
    ea = '{16'hAA, 16'hBB, 16'hAA};
    do_reset();
    for (int k = 0; k < 4; k++) push(v[k]);
    nchk++;
    if (cnt[0] !== 4'd3 || cnt[1] !== 4'd4 || dc[0] !== 16'd0) begin
      nfail++;
      $display("FAIL dup_count got %0d/%0d drop %0d exp 3/4 drop 0",
               cnt[0], cnt[1], dc[0]);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        nchk++;
        if (od[0] !== ea[k]) begin
          nfail++;
          $display("FAIL dup_f k=%0d got %h exp %h", k, od[0], ea[k]);
        end
      end
      nchk++;
      if (od[1] !== v[k]) begin
        nfail++;
        $display("FAIL dup_nf k=%0d got %h exp %h", k, od[1], v[k]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_policy();
    do_reset();
    for (int k = 1; k <= 10; k++) push(W'(k));
    nchk++;
    if (cnt[0] !== 4'd8 || dc[0] !== 16'd2 || of[0] !== 1'b1 ||
        cnt[2] !== 4'd8 || dc[2] !== 16'd2 || of[2] !== 1'b1) begin
      nfail++;
      $display("FAIL full_state c=%0d/%0d d=%0d/%0d o=%b/%b exp 8 2 1",
               cnt[0], cnt[2], dc[0], dc[2], of[0], of[2]);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nchk++;
      if (od[0] !== W'(k) || od[2] !== W'(k + 2)) begin
        nfail++;
        $display("FAIL full_drain k=%0d drop=%0d ovw=%0d exp %0d %0d",
                 k, od[0], od[2], k, k + 2);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 8; k++) push(W'(k));
    out_ready = 1'b1;
    push(W'(9));
    nchk++;
    if (cnt[0] !== 4'd8 || dc[0] !== 16'd0 || of[0] !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_full c=%0d d=%0d o=%b exp 8 0 0",
               cnt[0], dc[0], of[0]);
    end
    for (int k = 2; k <= 9; k++) begin
      nchk++;
      if (od[0] !== W'(k)) begin
        nfail++;
        $display("FAIL b2b_drain got %0d exp %0d", od[0], k);
      end
      tick();
    end
    nchk++;
    if (ov[0] !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_empty out_valid %b exp 0", ov[0]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow_reset();
    do_reset();
    for (int k = 1; k <= 9; k++) push(W'(k));
    clr = 1'b1;
    push(W'(10));
    nchk++;
    if (of[0] !== 1'b1 || dc[0] !== 16'd2) begin
      nfail++;
      $display("FAIL ovf_setwins o=%b d=%0d exp 1 2", of[0], dc[0]);
    end
    tick();
    clr = 1'b0;
    nchk++;
    if (of[0] !== 1'b0 || dc[0] !== 16'd2) begin
      nfail++;
      $display("FAIL ovf_clear o=%b d=%0d exp 0 2", of[0], dc[0]);
    end
    do_reset();
    for (int k = 1; k <= 5; k++) push(W'(k));
    nchk++;
    if (cnt[0] !== 4'd5) begin
      nfail++;
      $display("FAIL mid_fill c=%0d exp 5", cnt[0]);
    end
    rst = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (ov[i] !== 1'b0 || cnt[i] !== 4'd0) begin
        nfail++;
        $display("FAIL async_rst inst%0d v=%b c=%0d exp 0 0",
                 i, ov[i], cnt[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    push(W'(5));
    nchk++;
    if (cnt[0] !== 4'd1 || od[0] !== W'(5)) begin
      nfail++;
      $display("FAIL post_rst c=%0d d=%0d exp 1 5", cnt[0], od[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom_range(0, 5));
      out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (cnt[i] !== 4'(mq[i].size()) ||
            ov[i] !== (mq[i].size() != 0) ||
            dc[i] !== 16'(mdrop[i]) || of[i] !== movf[i]) begin
          nfail++;
          $display("FAIL rand n=%0d inst%0d c=%0d v=%b d=%0d o=%b exp c=%0d d=%0d o=%b",
                   n, i, cnt[i], ov[i], dc[i], of[i],
                   mq[i].size(), mdrop[i], movf[i]);
        end
        if (mq[i].size() != 0) begin
          nchk++;
          if (od[i] !== mq[i][0]) begin
            nfail++;
            $display("FAIL rand_data n=%0d inst%0d got %h exp %h",
                     n, i, od[i], mq[i][0]);
          end
        end
      end
    end
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_full_policy();
    test_back_to_back();
    test_overflow_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
